// File: rtl/gated_event_counter_pkg.sv
// Shared types for the gated event counter.
// FSM state encoding used by the top-level controller.
package gated_event_counter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } gec_state_t;

endpackage

// File: rtl/gated_event_counter_sync_rise_det.sv
// Synchroniser plus rising-edge pulse for an asynchronous input.
// Reusable for any async level that must be counted as edges.
module sync_rise_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_async,
    output logic q_sync,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // shift the async level through the chain, keep last value for edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_async};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_sync = sync_q[STAGES-1];
    assign rise   = q_sync & ~prev_q;

endmodule

// File: rtl/gated_event_counter.sv
// Counts synchronised event edges while gate is high, then
// offers the saturating count through a valid/ready slot.
module gated_event_counter #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gate,
    input  logic             evt_in,
    output logic [CNT_W-1:0] cnt_out,
    output logic             cnt_sat,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic             overrun
);

    import gated_event_counter_pkg::*;

    gec_state_t       state;
    gec_state_t       state_nxt;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] acc_nxt;
    logic             sat;
    logic             sat_nxt;
    logic             done;
    logic             slot_free;
    logic             gate_q;
    logic             gate_rise;
    logic             gate_fall;
    logic             evt_rise;

    sync_rise_det #(
        .STAGES (SYNC_STAGES)
    ) u_evt_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_async (evt_in),
        .q_sync  (),
        .rise    (evt_rise)
    );

    // gate delay; resets high so a gate already up is not a window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_q <= 1'b1;
        end else begin
            gate_q <= gate;
        end
    end

    assign gate_rise = gate & ~gate_q;
    assign gate_fall = ~gate & gate_q;
    assign slot_free = ~cnt_valid | cnt_ready;

    // window FSM with saturating accumulator
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        sat_nxt   = sat;
        done      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (gate_rise) begin
                    state_nxt = ST_COUNT;
                    acc_nxt   = CNT_W'(evt_rise);
                    sat_nxt   = 1'b0;
                end
            end
            ST_COUNT: begin
                if (gate_fall) begin
                    state_nxt = ST_IDLE;
                    done      = 1'b1;
                end else if (evt_rise) begin
                    if (&acc) begin
                        sat_nxt = 1'b1;
                    end else begin
                        acc_nxt = acc + 1'b1;
                    end
                end
            end
        endcase
    end

    // FSM and accumulator state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            acc   <= '0;
            sat   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            sat   <= sat_nxt;
        end
    end

    // result slot: load when free, otherwise drop and flag overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_out   <= '0;
            cnt_sat   <= 1'b0;
            cnt_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (done && slot_free) begin
                cnt_out   <= acc;
                cnt_sat   <= sat;
                cnt_valid <= 1'b1;
            end else if (cnt_valid && cnt_ready) begin
                cnt_valid <= 1'b0;
            end
            if (done && !slot_free) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gated_event_counter.sv
// Scoreboard bench for gated_event_counter.
// Windows and events are laid out as per-cycle tables.
module tb_gated_event_counter;

    localparam int CNT_W = 4;
    localparam int SS    = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;
    localparam int SLEN  = 4096;

    typedef struct {
        int cnt;
        bit sat;
        int due;
    } exp_t;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             gate      = 1'b1;
    logic             evt_in    = 1'b0;
    logic             cnt_ready = 1'b1;
    logic [CNT_W-1:0] cnt_out;
    logic             cnt_sat;
    logic             cnt_valid;
    logic             overrun;

    exp_t q[$];
    exp_t m;
    int   tests      = 0;
    int   fails      = 0;
    int   cyc        = 0;
    bit   g_a[SLEN];
    bit   e_a[SLEN];
    bit   hold_mode  = 1'b0;
    bit   slot_taken = 1'b0;

    gated_event_counter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .gate      (gate),
        .evt_in    (evt_in),
        .cnt_out   (cnt_out),
        .cnt_sat   (cnt_sat),
        .cnt_valid (cnt_valid),
        .cnt_ready (cnt_ready),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // pop one expected result per accepted transfer
    always @(negedge clk) begin
        if (rst_n && cnt_valid && cnt_ready) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_result: got cnt=%0d sat=%0d at cyc %0d, expected none",
                         cnt_out, cnt_sat, cyc);
            end else begin
                m = q.pop_front();
                if (int'(cnt_out) != m.cnt || cnt_sat != m.sat ||
                    (m.due >= 0 && cyc != m.due)) begin
                    fails++;
                    $display("FAIL result: got cnt=%0d sat=%0d cyc=%0d, expected cnt=%0d sat=%0d due=%0d",
                             cnt_out, cnt_sat, cyc, m.cnt, m.sat, m.due);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clr();
        for (int i = 0; i < SLEN; i++) begin
            g_a[i] = 1'b0;
            e_a[i] = 1'b0;
        end
    endtask

    task automatic set_gate(input int a, input int b);
        for (int i = a; i <= b; i++) g_a[i] = 1'b1;
    endtask

    task automatic pulse(input int a, input int hi);
        for (int i = a; i < a + hi; i++) e_a[i] = 1'b1;
    endtask

    task automatic pulses(input int a, input int n, input int hi, input int lo);
        for (int k = 0; k < n; k++) pulse(a + k * (hi + lo), hi);
    endtask

    // an event counts if its synchronised arrival lies in [r, f)
    function automatic int count_events(input int r, input int f);
        int n = 0;
        for (int j = 1; j < SLEN; j++) begin
            if (e_a[j] && !e_a[j-1] && j + SS >= r && j + SS < f) n++;
        end
        return n;
    endfunction

    // drive the tables; predict each window's result at its falling edge
    task automatic play(input int len);
        bit   pg  = 1'b0;
        bit   win = 1'b0;
        int   r   = 0;
        int   n;
        exp_t e;
        for (int k = 0; k < len + 12; k++) begin
            gate   = g_a[k];
            evt_in = e_a[k];
            if (g_a[k] && !pg) begin
                r   = k;
                win = 1'b1;
            end
            if (!g_a[k] && pg && win) begin
                n     = count_events(r, k);
                e.cnt = (n > MAXC) ? MAXC : n;
                e.sat = (n > MAXC);
                e.due = hold_mode ? -1 : cyc + 1;
                if (!hold_mode || !slot_taken) q.push_back(e);
                slot_taken = 1'b1;
            end
            pg = g_a[k];
            step();
        end
    endtask

    task automatic build_random(input int len);
        int idx = 2;
        int pos = 0;
        int wl;
        clr();
        while (idx < len - 80) begin
            idx += $urandom_range(1, 6);
            wl   = $urandom_range(1, 70);
            set_gate(idx, idx + wl - 1);
            idx += wl;
        end
        while (pos < len - 20) begin
            pos += $urandom_range(2, 6);
            wl   = $urandom_range(2, 3);
            pulse(pos, wl);
            pos += wl;
        end
    endtask

    initial begin
        // reset with gate already high, then held high: no window
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cnt_out", cnt_out, 0);
        chk("rst_cnt_sat", cnt_sat, 0);
        chk("rst_cnt_valid", cnt_valid, 0);
        chk("rst_overrun", overrun, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (20) step();
        chk("gate_high_at_reset_valid", cnt_valid, 0);
        gate = 1'b0;
        repeat (5) step();
        chk("gate_fall_in_idle_valid", cnt_valid, 0);

        // ten events in a 50-clk window
        clr();
        set_gate(5, 54);
        pulses(4, 10, 2, 3);
        play(60);

        // saturation: 20 events into a 4-bit count
        clr();
        set_gate(3, 92);
        pulses(3, 20, 2, 2);
        play(100);

        // consumer stalled: second window dropped, overrun sticky
        cnt_ready  = 1'b0;
        hold_mode  = 1'b1;
        slot_taken = 1'b0;
        clr();
        set_gate(3, 25);
        pulses(4, 3, 2, 3);
        set_gate(30, 60);
        pulses(32, 5, 2, 3);
        play(65);
        chk("stall_valid_held", cnt_valid, 1);
        chk("stall_cnt_out_first", cnt_out, 3);
        chk("stall_overrun", overrun, 1);
        hold_mode = 1'b0;
        cnt_ready = 1'b1;
        step();
        chk("accept_valid_drop", cnt_valid, 0);
        chk("accept_overrun_sticky", overrun, 1);
        chk("accept_queue_empty", q.size(), 0);

        // edges coincident with gate edges, 1-clk and back-to-back windows
        clr();
        set_gate(10, 19);
        pulse(8, 2);
        pulse(13, 2);
        pulse(18, 2);
        set_gate(30, 30);
        pulse(28, 2);
        set_gate(40, 40);
        pulse(39, 2);
        set_gate(50, 59);
        set_gate(61, 70);
        pulse(55, 2);
        pulse(62, 2);
        play(75);

        // reset mid-window after seven events
        gate = 1'b1;
        step();
        for (int i = 0; i < 7; i++) begin
            evt_in = 1'b1;
            repeat (2) step();
            evt_in = 1'b0;
            repeat (2) step();
        end
        repeat (4) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_cnt_out", cnt_out, 0);
        chk("midrst_cnt_sat", cnt_sat, 0);
        chk("midrst_cnt_valid", cnt_valid, 0);
        chk("midrst_overrun", overrun, 0);
        gate   = 1'b0;
        evt_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();
        clr();
        set_gate(5, 30);
        pulse(8, 2);
        pulse(15, 2);
        play(35);

        // randomized windows and events
        for (int t = 0; t < 3; t++) begin
            build_random(2000);
            play(2000);
        end
        chk("random_no_overrun", overrun, 0);

        for (int i = 0; i < 50 && q.size() != 0; i++) step();
        chk("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
